// File: rtl/mesh_pkg.sv
// mesh_pkg: shared state encoding and sizing helpers for the mesh job sequencer.
package mesh_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} seq_state_t;
  localparam int MESH_ROWS = 128;
  localparam int MESH_COLS = 128;
  localparam int MESH_BEATS = MESH_ROWS * MESH_COLS;
  localparam int MESH_ADDR_W = 14;
  function automatic int beat_count(input int rows, input int cols);
    return rows * cols;
  endfunction
  function automatic int addr_width(input int row_w, input int col_w);
    return row_w + col_w;
  endfunction
endpackage

// File: rtl/mesh_job_sequencer.sv
// mesh_job_sequencer: per-job weight preload, start pulse, fixed-latency wait and done.
// Optional MESH_SEQ_ABORT_EN adds an abort input that drops an in-flight job.
module mesh_job_sequencer
  import mesh_pkg::*;
#(
  parameter int DW          = 8,
  parameter int ROWS        = 128,
  parameter int COLS        = 128,
  parameter int ROW_W       = 7,
  parameter int COL_W       = 7,
  parameter int LAT_W       = 9,
  parameter int COMPUTE_LAT = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef MESH_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic                   job_reload,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DW-1:0]          w_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   start,
  output logic                   busy,
  output logic                   done
);
  localparam int AW = addr_width(ROW_W, COL_W);
  localparam int BEATS = beat_count(ROWS, COLS);
  localparam bit POW2 = (COLS == (1 << COL_W));
  seq_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, pa_q, pa_d, addr;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [DW-1:0] pd_q, pd_d;
  logic loaded_q, loaded_d, pv_q, pv_d, col_wrap, last;
  assign job_ready = state_q == IDLE;
  assign w_ready = state_q == LOAD;
  assign start = state_q == FIRE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign preload_valid = pv_q;
  assign preload_addr = pa_q;
  assign preload_data = pd_q;
  // Non-power-of-two column counts need the split row/col counters for the address.
  assign addr = POW2 ? idx_q : {row_q, col_q};
  assign col_wrap = col_q == COL_W'(COLS - 1);
  assign last = idx_q == AW'(BEATS - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    lat_d = lat_q;
    loaded_d = loaded_q;
    pv_d = 1'b0;
    pa_d = pa_q;
    pd_d = pd_q;
    case (state_q)
      IDLE: if (job_valid) begin
        state_d = (job_reload || !loaded_q) ? LOAD : FIRE;
        idx_d = '0;
        row_d = '0;
        col_d = '0;
      end
      LOAD: if (w_valid) begin
        pv_d = 1'b1;
        pa_d = addr;
        pd_d = w_data;
        idx_d = idx_q + AW'(1);
        col_d = col_wrap ? '0 : col_q + COL_W'(1);
        row_d = col_wrap ? row_q + ROW_W'(1) : row_q;
        if (last) begin
          state_d = FIRE;
          loaded_d = 1'b1;
        end
      end
      FIRE: begin
        lat_d = LAT_W'(COMPUTE_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        state_d = (lat_q == '0) ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
`ifdef MESH_SEQ_ABORT_EN
    if (abort && (state_q == LOAD || state_q == FIRE || state_q == WAIT)) begin
      state_d = IDLE;
      pv_d = 1'b0;
      loaded_d = (state_q == LOAD) ? 1'b0 : loaded_q;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
      lat_q <= '0;
      loaded_q <= 1'b0;
      pv_q <= 1'b0;
      pa_q <= '0;
      pd_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      row_q <= row_d;
      col_q <= col_d;
      lat_q <= lat_d;
      loaded_q <= loaded_d;
      pv_q <= pv_d;
      pa_q <= pa_d;
      pd_q <= pd_d;
    end
  end
endmodule

// File: tb/tb_mesh_job_sequencer.sv
// tb_mesh_job_sequencer: directed jobs on a 2x2 mesh with a preload scoreboard.
module tb_mesh_job_sequencer;
  localparam int DW = 8, ROWS = 2, COLS = 2, ROW_W = 1, COL_W = 1, LAT_W = 9, LAT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic job_valid = 1'b0, job_reload = 1'b0, w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic job_ready, w_ready, preload_valid, start, busy, done;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0] preload_data;
`ifdef MESH_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  logic [9:0] exp_q[$];
  logic [9:0] exp_e;
  int tests = 0, fails = 0, cyc = 0;
  int start_cyc = 0, done_cyc = 0, acc_cyc = 0, last_pv_cyc = 0;
  int pv_cnt = 0, dones = 0, accepts = 0, min_gap = 1000, last_done = -1;

  mesh_job_sequencer #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .LAT_W(LAT_W), .COMPUTE_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MESH_SEQ_ABORT_EN
    .abort(abort),
`endif
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_reload(job_reload),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data(w_data),
    .preload_valid(preload_valid),
    .preload_addr(preload_addr),
    .preload_data(preload_data),
    .start(start),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (preload_valid) begin
      pv_cnt++;
      last_pv_cyc = cyc;
      if (exp_q.size() == 0) check("preload_extra", int'({preload_addr, preload_data}), -1);
      else begin
        exp_e = exp_q.pop_front();
        check("preload_write", int'({preload_addr, preload_data}), int'(exp_e));
      end
    end
    if (start) begin
      start_cyc = cyc;
      if (last_done >= 0 && cyc - last_done < min_gap) min_gap = cyc - last_done;
    end
    if (done) begin
      done_cyc = cyc;
      last_done = cyc;
      dones++;
    end
    if (job_valid && job_ready) accepts++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic job(input logic rl);
    job_valid = 1'b1;
    job_reload = rl;
    tick();
    job_valid = 1'b0;
    acc_cyc = cyc - 1;
  endtask

  task automatic beat(input logic [7:0] d, input int a);
    logic [1:0] a2;
    a2 = a[1:0];
    exp_q.push_back({a2, d});
    w_valid = 1'b1;
    w_data = d;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = dones;
    n = 0;
    while (dones == d0 && n < 100) begin
      tick();
      n++;
    end
    check(tag, dones - d0, 1);
  endtask

  task automatic reset_checks(input string p);
    check({p, "_job_ready"}, job_ready, 1);
    check({p, "_busy"}, busy, 0);
    check({p, "_w_ready"}, w_ready, 0);
    check({p, "_start"}, start, 0);
    check({p, "_done"}, done, 0);
    check({p, "_preload_valid"}, preload_valid, 0);
    check({p, "_preload_addr"}, preload_addr, 0);
    check({p, "_preload_data"}, preload_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, d0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    reset_checks("reset");
    // Reuse job with nothing resident is forced through LOAD.
    job(1'b0);
    check("forced_load_w_ready", w_ready, 1);
    beat(8'd1, 0); beat(8'd2, 1); beat(8'd3, 2); beat(8'd4, 3);
    wait_done("load_done_seen");
    check("load_start_latency", start_cyc - acc_cyc, ROWS * COLS + 1);
    check("load_start_with_last_write", start_cyc, last_pv_cyc);
    check("load_done_after_start", done_cyc - start_cyc, LAT + 1);
    p0 = pv_cnt;
    job(1'b0);
    check("reuse_start_now", start, 1);
    tick();
    w_valid = 1'b1;
    w_data = 8'hAA;
    check("wait_w_ready_low", w_ready, 0);
    tick();
    w_valid = 1'b0;
    wait_done("reuse_done_seen");
    check("reuse_start_latency", start_cyc - acc_cyc, 1);
    check("reuse_done_latency", done_cyc - acc_cyc, LAT + 2);
    check("reuse_no_preload", pv_cnt - p0, 0);
    job(1'b1);
    beat(8'd5, 0);
    repeat (3) tick();
    beat(8'd6, 1); beat(8'd7, 2); beat(8'd8, 3);
    wait_done("stall_done_seen");
    check("stall_start_latency", start_cyc - acc_cyc, ROWS * COLS + 1 + 3);
    check("stall_start_with_last_write", start_cyc, last_pv_cyc);
    check("stall_done_after_start", done_cyc - start_cyc, LAT + 1);
    a0 = accepts;
    d0 = dones;
    min_gap = 1000;
    job_valid = 1'b1;
    job_reload = 1'b0;
    repeat (21) tick();
    job_valid = 1'b0;
    for (int i = 0; i < 50 && busy; i++) tick();
    check("held_accepts", accepts - a0, 3);
    check("held_dones", dones - d0, 3);
    check("done_to_start_gap", min_gap, 2);
    job(1'b0);
    tick();
    tick();
    check("midwait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    job(1'b0);
    check("reset_clears_loaded", w_ready, 1);
    beat(8'd9, 0); beat(8'd10, 1); beat(8'd11, 2); beat(8'd12, 3);
    wait_done("post_reset_done_seen");
`ifdef MESH_SEQ_ABORT_EN
    job(1'b1);
    beat(8'd21, 0); beat(8'd22, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_job_ready", job_ready, 1);
    d0 = dones;
    repeat (8) tick();
    check("abort_no_done", dones - d0, 0);
    job(1'b0);
    check("abort_clears_loaded", w_ready, 1);
    beat(8'd31, 0); beat(8'd32, 1); beat(8'd33, 2); beat(8'd34, 3);
    wait_done("abort_reload_done_seen");
`endif
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mesh_job_sequencer.md
# mesh_job_sequencer

Job-level controller that sits in front of the `fsm_controller`/`mesh_2d_array` pair in `top`. It accepts one job command at a time. For each job it optionally streams a full weight matrix from a ready/valid source into the mesh preload port in row-major order. It then pulses `start`, waits a fixed compute latency, and signals `done`. It replaces the externally driven `preload_*`/`start` pins with a single handshaked interface.

## Interface

Parameters:

- `DW`, 8, weight width in bits
- `ROWS`, 128, mesh rows
- `COLS`, 128, mesh columns
- `ROW_W`, 7, row-index width (clog2 ROWS)
- `COL_W`, 7, column-index width (clog2 COLS)
- `LAT_W`, 9, width of the compute-latency counter
- `COMPUTE_LAT`, 256, cycles from `start` pulse to result-valid; must be ≥1 and < 2^LAT_W

Ports:

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `job_valid`  in  1  job command present
- `job_ready`  out  1  sequencer can accept a job
- `job_reload`  in  1  1 = load new weights before compute; 0 = reuse resident weights
- `w_valid`  in  1  weight beat present
- `w_ready`  out  1  sequencer accepts weight beat
- `w_data`  in  DW  signed weight beat
- `preload_valid`  out  1  mesh preload write strobe
- `preload_addr`  out  ROW_W+COL_W  {row, col}, row in upper bits
- `preload_data`  out  DW  signed weight to mesh
- `start`  out  1  one-cycle compute trigger to `fsm_controller`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse; mesh `result_flat` is valid this cycle

## Operation

- States: IDLE, LOAD, FIRE, WAIT, DONE. The state is registered.
- IDLE: `job_ready`=1. On `job_valid && job_ready`:
  - go to LOAD if `job_reload` = 1 or `loaded` = 0;
  - otherwise go to FIRE.
- `loaded` flag:
  - cleared at reset;
  - set when the final weight beat is accepted.
  - A reuse job issued before any load is therefore forced through LOAD.
- LOAD:
  - `w_ready`=1, and is 0 in every other state.
  - Each accepted beat (`w_valid && w_ready`) increments the beat index `idx` (0 … ROWS*COLS-1, cleared on entry to LOAD).
  - On the following cycle the block drives `preload_valid`=1, `preload_addr`=`idx` of that beat and `preload_data`=that beat's `w_data`. These outputs are registered.
  - Stalls (`w_valid`=0) hold the state and `idx`, and give `preload_valid`=0.
  - Acceptance of beat ROWS*COLS-1 moves the block to FIRE.
- Address mapping: row = idx / COLS, col = idx % COLS.
  - When COLS = 2^COL_W, `preload_addr` equals `idx` directly.
  - Otherwise the block keeps a separate row counter and column counter; the column counter wraps at COLS-1 and increments the row.
- FIRE: `start`=1 for exactly one cycle. The latency counter loads COMPUTE_LAT-1. Next state is WAIT.
- WAIT: the counter decrements each cycle. When the counter reads 0, the next state is DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `job_valid` is ignored outside IDLE. `w_valid` is ignored outside LOAD.
- Reset mid-job: all state clears asynchronously, including `loaded`, and the partial load is discarded.

## Timing

- Reset values:
  - `job_ready`=1, `busy`=0, `w_ready`=0, `start`=0, `done`=0;
  - `preload_valid`=0, `preload_addr`=0, `preload_data`=0;
  - `loaded`=0.
- Cycle accounting:
  - Job accepted at cycle T gives LOAD at T+1.
  - With no stalls, beats are accepted at T+1 … T+N, where N = ROWS*COLS.
  - `preload_valid` is high on T+2 … T+N+1.
  - FIRE (`start`) is at T+N+1, the same cycle as the last preload write. The mesh samples the preload and `start` together, and `fsm_controller` begins compute on the next cycle.
  - `done` is at T+N+1+COMPUTE_LAT+1.
- Reuse job accepted at T: `start` at T+1, `done` at T+COMPUTE_LAT+2.
- Back-to-back jobs: `job_ready` rises in the cycle after DONE. The minimum gap between `done` and the next `start` is 2 cycles.

## Configuration

- `MESH_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - Asserted in LOAD, FIRE or WAIT, it returns the block to IDLE on the next cycle, with no `done` pulse.
  - An abort during LOAD also clears `loaded`.
  - `abort` in IDLE or DONE has no effect; DONE completes normally.
- Undefined: the port is absent, and every job runs to completion.

## Structure

- Shared package `mesh_pkg`:
  - state enum `seq_state_t` {IDLE, LOAD, FIRE, WAIT, DONE};
  - localparam for the beat count ROWS*COLS;
  - preload address width.
- No sub-module. The beat counter and latency counter are inline.
- `top` instantiates the sequencer ahead of `fsm_controller`, which is unchanged.

## Test plan

Unless a scenario says otherwise, run with ROWS=COLS=2, ROW_W=COL_W=1, COMPUTE_LAT=4.

- Reset, then idle → `job_ready`=1 and every other output 0. Assert `rst_n` low mid-WAIT → outputs return to their reset values immediately.
- Reload job, then weights 1,2,3,4 with no stalls → preload writes (addr,data)=(0,1),(1,2),(2,3),(3,4) on consecutive cycles; `start` aligned with the last write; `done` 5 cycles after `start`.
- Reload job with `w_valid` low for 3 cycles after beat 1 → no `preload_valid` during the gap; addresses stay contiguous; `start` delayed by 3 cycles.
- Reuse job immediately after reset → forced LOAD: `w_ready` asserts. Then a second reuse job → `start` one cycle after acceptance, with no preload writes.
- `job_valid` held high throughout → exactly one job accepted per `done`. `w_valid` pulsed in WAIT → `w_ready`=0 and no preload write.
- With `MESH_SEQ_ABORT_EN`: `abort` after beat 2 → IDLE next cycle, no `done`. A following reuse job is forced through LOAD.
